neuron_accum: RTL and testbench
===============================

# neuron_accum

Downstream neighbour of the Q8.8 fixed-point multiplier stage. Consumes a stream of signed 16-bit products and accumulates `N_INPUTS` of them into a wide register. It then adds a bias, saturates to 16 bits and optionally applies ReLU. The single neuron activation it produces is handed to the next layer over a valid/ready handshake.

## Interface
- `N_INPUTS`, default 4: products summed per activation; range 1–256.
- `ACC_W`, default 24: accumulator width; must be ≥ 16 + clog2(`N_INPUTS`).
- `clk` — input, 1 bit: single clock; all state updates on rising edge.
- `reset` — input, 1 bit: asynchronous, active-high; clears all state immediately.
- `prod_in` — input, 16 bits: signed Q8.8 product from the multiplier.
- `prod_valid` — input, 1 bit: `prod_in` is valid this cycle.
- `prod_ready` — output, 1 bit: block accepts a product this cycle.
- `bias` — input, 16 bits: signed Q8.8 bias; sampled in the FINISH cycle.
- `relu_en` — input, 1 bit: when 1, negative results are clamped to 0; sampled in the FINISH cycle.
- `act_out` — output, 16 bits: signed Q8.8 activation; registered.
- `act_valid` — output, 1 bit: `act_out` is valid.
- `act_ready` — input, 1 bit: downstream accepts `act_out`.

## Operation
- **State machine:** three states, ACCUM → FINISH → HOLD → ACCUM.
- **ACCUM**
  - `prod_ready`=1.
  - On each edge with `prod_valid`=1: `acc <= acc + sext(prod_in)`, `cnt <= cnt+1`.
  - When a product is accepted with `cnt`==`N_INPUTS`-1, the next state is FINISH.
  - Cycles with `prod_valid`=0 change nothing.
- **FINISH** (exactly 1 cycle)
  - `prod_ready`=0.
  - `sum = acc + sext(bias)`, computed in `ACC_W` bits.
  - Saturate `sum` to the range [16'h8000, 16'h7FFF].
  - If `relu_en` and the result is negative, force 16'h0000.
  - Register the result into `act_out`; `act_valid` <= 1; go to HOLD.
- **HOLD**
  - `prod_ready`=0; `act_out` and `act_valid`=1 held stable.
  - On an edge with `act_ready`=1: `act_valid` <= 0, `acc` <= 0, `cnt` <= 0, go to ACCUM.
  - `act_out` keeps its last value after the handoff. It is only meaningful while `act_valid`=1.
- **Signals ignored outside their sampling windows**
  - `prod_in`/`prod_valid` are ignored outside ACCUM: no accumulation, no count.
  - `act_ready` is ignored outside HOLD.
- **Arithmetic**
  - Two's complement throughout; products are sign-extended to `ACC_W`.
  - The accumulator never overflows for legal `ACC_W`; saturation is applied only at the 16-bit output.
- **Reset:** asynchronous and effective mid-operation. It forces:
  - state = ACCUM
  - `acc`=0, `cnt`=0
  - `act_out`=16'h0000, `act_valid`=0
  - consequently `prod_ready`=1 once reset deasserts.
  - Partial sums are discarded.

## Timing
- **Reset values:** `act_out`=16'h0000, `act_valid`=0, `prod_ready`=1 (in ACCUM, while reset is low).
- **`prod_ready`:** a combinational decode of state only. It does not depend on `prod_valid`.
- **Latency:** last product accepted at edge k → FINISH during cycle k..k+1 → `act_valid`=1 after edge k+1.
- **Minimum period:** `N_INPUTS` + 2 cycles per activation when `act_ready` is held at 1. That is N accept edges, then FINISH, then the HOLD handoff edge; the first product of the next group is accepted at the edge after the handoff.
- **Simultaneous events:** `reset` wins over every other input.
- **`N_INPUTS`=1:** ACCUM → FINISH after a single accept.

## Test plan
1. **Basic sum:** `N_INPUTS`=4, reset high for 16 ns then low; four consecutive 16'h0100, `bias`=0, `relu_en`=0, `act_ready`=1 → `act_out`=16'h0400; `act_valid` rises one edge after the 4th accept and is high for 1 cycle.
2. **Positive saturation:** four products 16'h7000, `bias`=0 → internal sum 24'h01C000 → `act_out`=16'h7FFF.
3. **Negative sum with and without ReLU:** four products 16'hFF00, `bias`=16'h0100.
   - `relu_en`=0 → `act_out`=16'hFD00.
   - Repeat with `relu_en`=1 → `act_out`=16'h0000.
   - Repeat with products 16'h8000 ×4, `relu_en`=0 → `act_out`=16'h8000 (negative saturation).
4. **Bubbles:** `prod_valid` toggled 1/0 on alternate cycles carrying 16'h0100 → result 16'h0400.
   - `cnt` advances only on valid cycles.
   - `act_valid` comes 1 edge after the 4th valid product.
5. **Backpressure:** hold `act_ready`=0 for 5 cycles after `act_valid` rises, with `prod_valid`=1 and `prod_in`=16'h0200 presented throughout.
   - `act_out` is stable and `prod_ready`=0 for those cycles.
   - After `act_ready`=1, the next group of four 16'h0100 yields 16'h0400, showing the stalled products were not absorbed.
6. **Reset mid-accumulation:** accept two products 16'h0100, then pulse `reset` asynchronously, mid-cycle.
   - `act_out`=0 and `act_valid`=0 immediately.
   - A following four 16'h0100 yield exactly 16'h0400.

Source files
------------

// File: rtl/neuron_accum.sv
// Sums N_INPUTS signed Q8.8 products, adds bias, saturates to 16 bits, optional ReLU.
// Result registered one cycle after the last accept; holds until act_ready, input stalled meanwhile.
module neuron_accum #(
  parameter int N_INPUTS = 4,
  parameter int ACC_W    = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] prod_in,
  input  logic        prod_valid,
  output logic        prod_ready,
  input  logic [15:0] bias,
  input  logic        relu_en,
  output logic [15:0] act_out,
  output logic        act_valid,
  input  logic        act_ready
);

  localparam int CNT_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_INPUTS - 1);

  typedef enum logic [1:0] {ACCUM, FINISH, HOLD} state_t;

  state_t                  state;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] sum;
  logic [CNT_W-1:0]        cnt;
  logic [ACC_W-16:0]       hi;
  logic [15:0]             sat;
  logic [15:0]             result;

  assign prod_ready = (state == ACCUM);

  // Bits above bit 15 must all equal the sign bit, otherwise the sum is out of 16-bit range.
  always_comb begin
    sum = acc + ACC_W'($signed(bias));
    hi  = sum[ACC_W-1:15];
    if (!sum[ACC_W-1] && (|hi)) begin
      sat = 16'h7FFF;
    end else if (sum[ACC_W-1] && !(&hi)) begin
      sat = 16'h8000;
    end else begin
      sat = sum[15:0];
    end
    result = (relu_en && sat[15]) ? 16'h0000 : sat;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ACCUM;
      acc       <= '0;
      cnt       <= '0;
      act_out   <= 16'h0000;
      act_valid <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (prod_valid) begin
            acc <= acc + ACC_W'($signed(prod_in));
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
              state <= FINISH;
            end
          end
        end
        FINISH: begin
          act_out   <= result;
          act_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (act_ready) begin
            act_valid <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            state     <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_accum.sv
// Bench for neuron_accum: table of product groups checked through a scoreboard,
// plus hand-written sequences for latency, bubbles, backpressure and reset.
module tb_neuron_accum;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] prod_in;
  logic        prod_valid;
  logic        prod_ready;
  logic [15:0] bias;
  logic        relu_en;
  logic [15:0] act_out;
  logic        act_valid;
  logic        act_ready;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];

  typedef struct packed {
    logic [15:0] p0;
    logic [15:0] p1;
    logic [15:0] p2;
    logic [15:0] p3;
    logic [15:0] b;
    logic        r;
    logic [15:0] e;
  } vec_t;

  vec_t tbl[13];

  neuron_accum #(.N_INPUTS(4), .ACC_W(24)) dut (
    .clk        (clk),
    .reset      (reset),
    .prod_in    (prod_in),
    .prod_valid (prod_valid),
    .prod_ready (prod_ready),
    .bias       (bias),
    .relu_en    (relu_en),
    .act_out    (act_out),
    .act_valid  (act_valid),
    .act_ready  (act_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  // Scoreboard: every handshake on the output pops one expected activation.
  always begin
    @(negedge clk);
    #2;
    if (!reset && act_valid && act_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_activation", 32'(act_out), 32'hFFFF_FFFF);
      end else begin
        check("act_out", 32'(act_out), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic send_prod(input logic [15:0] p, input logic [15:0] b, input logic r);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!prod_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) check("prod_ready_timeout", 32'(prod_ready), 32'd1);
    prod_in    = p;
    prod_valid = 1'b1;
    bias       = b;
    relu_en    = r;
    @(posedge clk);
  endtask

  task automatic send_group(input vec_t v, input bit push);
    if (push) exp_q.push_back(v.e);
    send_prod(v.p0, v.b, v.r);
    send_prod(v.p1, v.b, v.r);
    send_prod(v.p2, v.b, v.r);
    send_prod(v.p3, v.b, v.r);
  endtask

  // Called right after the accept edge of the last product, with act_ready=1.
  task automatic check_timing(input string tag);
    @(negedge clk);
    prod_valid = 1'b0;
    check({tag, "_finish_valid"}, 32'(act_valid), 32'd0);
    check({tag, "_finish_ready"}, 32'(prod_ready), 32'd0);
    @(negedge clk);
    check({tag, "_hold_valid"}, 32'(act_valid), 32'd1);
    check({tag, "_hold_ready"}, 32'(prod_ready), 32'd0);
    @(negedge clk);
    check({tag, "_after_valid"}, 32'(act_valid), 32'd0);
    check({tag, "_after_ready"}, 32'(prod_ready), 32'd1);
  endtask

  initial begin
    tbl[0]  = '{16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0000, 1'b0, 16'h0400};
    tbl[1]  = '{16'h7000, 16'h7000, 16'h7000, 16'h7000, 16'h0000, 1'b0, 16'h7FFF};
    tbl[2]  = '{16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00, 16'h0100, 1'b0, 16'hFD00};
    tbl[3]  = '{16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00, 16'h0100, 1'b1, 16'h0000};
    tbl[4]  = '{16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h0100, 1'b0, 16'h8000};
    tbl[5]  = '{16'h0180, 16'hFF80, 16'h0040, 16'h0010, 16'h0020, 1'b0, 16'h0170};
    tbl[6]  = '{16'h4000, 16'h3000, 16'h0000, 16'h0000, 16'h0FFF, 1'b0, 16'h7FFF};
    tbl[7]  = '{16'h4000, 16'h4000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h7FFF};
    tbl[8]  = '{16'hC000, 16'hC000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h8000};
    tbl[9]  = '{16'hC000, 16'hC000, 16'h0000, 16'h0000, 16'hFFFF, 1'b0, 16'h8000};
    tbl[10] = '{16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0000, 1'b1, 16'h0400};
    tbl[11] = '{16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'hFFFE, 1'b0, 16'hFFFF};
    tbl[12] = '{16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'hFFFE, 1'b1, 16'h0000};

    reset      = 1'b1;
    prod_in    = 16'h0000;
    prod_valid = 1'b0;
    bias       = 16'h0000;
    relu_en    = 1'b0;
    act_ready  = 1'b1;
    #12;
    check("reset_act_out", 32'(act_out), 32'h0);
    check("reset_act_valid", 32'(act_valid), 32'd0);
    #4;
    reset = 1'b0;
    #1;
    check("post_reset_prod_ready", 32'(prod_ready), 32'd1);

    // Basic sum with exact output timing.
    send_group(tbl[0], 1'b1);
    check_timing("basic");

    for (int i = 1; i < 13; i++) begin
      send_group(tbl[i], 1'b1);
      @(negedge clk);
      prod_valid = 1'b0;
    end

    // Bubbles: valid every other cycle.
    exp_q.push_back(16'h0400);
    send_prod(16'h0100, 16'h0000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      prod_valid = 1'b0;
      @(posedge clk);
      send_prod(16'h0100, 16'h0000, 1'b0);
    end
    check_timing("bubble");

    // Backpressure: stalled products must not be absorbed.
    act_ready = 1'b0;
    send_group(tbl[0], 1'b1);
    @(negedge clk);
    prod_in    = 16'h0200;
    prod_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_act_valid", 32'(act_valid), 32'd1);
      check("bp_prod_ready", 32'(prod_ready), 32'd0);
      check("bp_act_out", 32'(act_out), 32'h0400);
    end
    @(negedge clk);
    act_ready  = 1'b1;
    prod_valid = 1'b0;
    send_group(tbl[0], 1'b1);
    @(negedge clk);
    prod_valid = 1'b0;

    // Reset mid-accumulation, asserted mid-cycle.
    send_prod(16'h0100, 16'h0000, 1'b0);
    send_prod(16'h0100, 16'h0000, 1'b0);
    #3;
    reset      = 1'b1;
    prod_valid = 1'b0;
    #1;
    check("midrst_act_out", 32'(act_out), 32'h0);
    check("midrst_act_valid", 32'(act_valid), 32'd0);
    check("midrst_prod_ready", 32'(prod_ready), 32'd1);
    #2;
    reset = 1'b0;
    send_group(tbl[0], 1'b1);
    check_timing("after_midrst");

    // Reset while an activation is being held.
    act_ready = 1'b0;
    send_group(tbl[2], 1'b0);
    @(negedge clk);
    prod_valid = 1'b0;
    @(negedge clk);
    check("hold_pre_rst_valid", 32'(act_valid), 32'd1);
    #3;
    reset = 1'b1;
    #1;
    check("holdrst_act_out", 32'(act_out), 32'h0);
    check("holdrst_act_valid", 32'(act_valid), 32'd0);
    #2;
    reset     = 1'b0;
    act_ready = 1'b1;
    send_group(tbl[5], 1'b1);
    @(negedge clk);
    prod_valid = 1'b0;

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
